// File: rtl/dac_serial_tx.sv
// dac_serial_tx: WM8731 DAC serializer; buffers one {left,right} word and shifts it out MSB first per frame.
module dac_serial_tx #(
  parameter int BCLK_DIV = 4,
  parameter int CNT_W    = 8
) (
  input  logic             m_clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [31:0]      sample_data,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             b_clk,
  output logic             dac_lr_clk,
  output logic             dacdat,
  output logic             underrun,
  output logic [CNT_W-1:0] underrun_cnt
);
  localparam int DW = $clog2(BCLK_DIV);

  logic             r_run;
  logic [DW-1:0]    r_div_cnt;
  logic [5:0]       r_bit_cnt;
  logic             r_b_clk;
  logic             r_lr;
  logic             r_dat;
  logic [31:0]      r_shift;
  logic [31:0]      r_buf;
  logic             r_buf_full;
  logic             r_underrun;
  logic [CNT_W-1:0] r_ucnt;

  logic        w_xfer;
  logic        w_run;
  logic        w_tick;
  logic        w_rise;
  logic [5:0]  w_bit;
  logic        w_fs;
  logic        w_under;
  logic [31:0] w_word;

  // r_run delays the divider by one cycle so the first b_clk rise lands H edges after enable is seen
  assign w_xfer  = sample_valid && !r_buf_full;
  assign w_run   = enable && r_run;
  assign w_tick  = w_run && (r_div_cnt == DW'(BCLK_DIV - 1));
  assign w_rise  = w_tick && !r_b_clk;
  assign w_bit   = r_bit_cnt + 6'd1;
  assign w_fs    = w_rise && (w_bit == 6'd0);
  assign w_under = w_fs && !r_buf_full && !w_xfer;
  assign w_word  = r_buf_full ? r_buf : (w_xfer ? sample_data : 32'h0);

  always_ff @(posedge m_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run      <= 1'b0;
      r_div_cnt  <= '0;
      r_bit_cnt  <= 6'd63;
      r_b_clk    <= 1'b0;
      r_lr       <= 1'b0;
      r_dat      <= 1'b0;
      r_shift    <= '0;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_underrun <= 1'b0;
      r_ucnt     <= '0;
    end else begin
      r_run      <= enable;
      r_underrun <= w_under;
      if (w_under && !(&r_ucnt))
        r_ucnt <= r_ucnt + 1'b1;
      // a bypass transfer at frame start never touches the buffer
      if (w_fs)
        r_buf_full <= 1'b0;
      else if (w_xfer) begin
        r_buf      <= sample_data;
        r_buf_full <= 1'b1;
      end
      if (!w_run) begin
        r_div_cnt <= '0;
        r_bit_cnt <= 6'd63;
        r_b_clk   <= 1'b0;
        r_lr      <= 1'b0;
        r_dat     <= 1'b0;
        r_shift   <= '0;
      end else begin
        r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
        if (w_tick)
          r_b_clk <= !r_b_clk;
        if (w_rise) begin
          r_bit_cnt <= w_bit;
          if (w_bit == 6'd0) begin
            r_lr    <= 1'b1;
            r_dat   <= w_word[31];
            r_shift <= {w_word[30:0], 1'b0};
          end else begin
            if (w_bit == 6'd32)
              r_lr <= 1'b0;
            r_dat   <= !w_bit[5] && r_shift[31];
            r_shift <= {r_shift[30:0], 1'b0};
          end
        end
      end
    end
  end

  assign sample_ready = !r_buf_full;
  assign b_clk        = r_b_clk;
  assign dac_lr_clk   = r_lr;
  assign dacdat       = r_dat;
  assign underrun     = r_underrun;
  assign underrun_cnt = r_ucnt;
endmodule

// File: tb/tb_dac_serial_tx.sv
// tb_dac_serial_tx: scoreboard bench; a frame-level timing model predicts every serial output cycle by cycle.
module tb_dac_serial_tx;
  localparam int H  = 4;
  localparam int CW = 8;
  localparam int FR = 128 * H;

  logic          m_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [31:0]   sample_data = '0;
  logic          sample_valid = 1'b0;
  logic          sample_ready;
  logic          b_clk;
  logic          dac_lr_clk;
  logic          dacdat;
  logic          underrun;
  logic [CW-1:0] underrun_cnt;

  dac_serial_tx #(.BCLK_DIV(H), .CNT_W(CW)) dut (
    .m_clk(m_clk), .rst_n(rst_n), .enable(enable),
    .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .b_clk(b_clk), .dac_lr_clk(dac_lr_clk), .dacdat(dacdat),
    .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  always #5 m_clk = ~m_clk;

  typedef struct { logic [31:0] w; bit und; } frame_t;
  frame_t exp_q[$];
  int vectors = 0;
  int errors  = 0;

  // reference model: m_t counts edges since enable was seen high; frames start at t = H + k*128H
  int          m_t = -1;
  bit          m_full = 0;
  logic [31:0] m_buf = '0;
  int          m_ucnt = 0;
  bit          m_xfer = 0;

  function automatic bit is_fs(int t);
    return t >= H && (t - H) % FR == 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    errors++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic model_step();
    bit x;
    m_xfer = 0;
    m_t = enable ? m_t + 1 : -1;
    x = sample_valid && !m_full;
    if (is_fs(m_t)) begin
      if (m_full) begin
        exp_q.push_back('{m_buf, 1'b0});
        m_full = 0;
      end else if (x) begin
        exp_q.push_back('{sample_data, 1'b0});
        m_xfer = 1;
      end else begin
        exp_q.push_back('{32'h0, 1'b1});
        if (m_ucnt < (1 << CW) - 1) m_ucnt++;
      end
    end else if (x) begin
      m_full = 1;
      m_buf  = sample_data;
      m_xfer = 1;
    end
  endtask

  task automatic cyc(input bit en, input bit v, input logic [31:0] d);
    @(negedge m_clk);
    #1;
    enable = en;
    sample_valid = v;
    sample_data = d;
    model_step();
  endtask

  task automatic idle(input int n, input bit en);
    repeat (n) cyc(en, 1'b0, $urandom());
  endtask

  task automatic do_reset();
    @(negedge m_clk);
    #1;
    rst_n = 0;
    enable = 0;
    sample_valid = 0;
    m_t = -1;
    m_full = 0;
    m_ucnt = 0;
    exp_q.delete();
    repeat (3) @(negedge m_clk);
    #1;
    rst_n = 1;
    model_step();
  endtask

  logic e_smp;
  always @(posedge m_clk or negedge rst_n)
    if (!rst_n) e_smp <= 1'b0;
    else e_smp <= enable;

  // monitor: pops one expected frame per dac_lr_clk rise and checks every output each cycle
  initial begin
    bit          p_b = 0, p_lr = 0, in_fr = 0, have_cur = 0, lr_rise, zor;
    frame_t      cur;
    logic [31:0] asm_w;
    int          nb = 0, cnt = 0, last_b = -1, last_lr = -1, n;
    logic        eb, elr, ed;
    forever begin
      @(negedge m_clk);
      cnt++;
      if (!rst_n) begin
        chk("reset b_clk", b_clk, 0);
        chk("reset lr", dac_lr_clk, 0);
        chk("reset dacdat", dacdat, 0);
        chk("reset ready", sample_ready, 1);
        chk("reset underrun", underrun, 0);
        chk("reset ucnt", underrun_cnt, 0);
        in_fr = 0; have_cur = 0; last_b = -1; last_lr = -1;
      end else begin
        lr_rise = e_smp && dac_lr_clk && !p_lr;
        if (lr_rise) begin
          if (exp_q.size() == 0) begin
            timeout("scoreboard empty at frame start");
            have_cur = 0;
          end else begin
            cur = exp_q.pop_front();
            have_cur = 1;
          end
          if (last_lr >= 0) chk("lr period", cnt - last_lr, FR);
          last_lr = cnt;
          in_fr = 1; nb = 0; zor = 0; asm_w = '0;
        end
        if (e_smp && p_lr && !dac_lr_clk && last_lr >= 0)
          chk("lr high time", cnt - last_lr, 64 * H);
        if (e_smp && b_clk && !p_b) begin
          if (last_b >= 0) chk("b_clk period", cnt - last_b, 2 * H);
          last_b = cnt;
        end
        if (e_smp && p_b && !b_clk && in_fr) begin
          if (nb < 32) asm_w = {asm_w[30:0], dacdat};
          else zor = zor | dacdat;
          nb++;
          if (nb == 32) chk("frame word", asm_w, have_cur ? cur.w : 32'hx);
          if (nb == 64) begin
            chk("right-half zeros", zor, 0);
            in_fr = 0;
          end
        end
        eb = 0; elr = 0; ed = 0;
        if (m_t >= H) begin
          eb  = ((m_t - H) % (2 * H)) < H;
          elr = ((m_t - H) % FR) < 64 * H;
          n   = ((m_t - H) / (2 * H)) % 64;
          ed  = (n < 32 && have_cur) ? cur.w[31 - n] : 1'b0;
        end
        chk("b_clk", b_clk, eb);
        chk("dac_lr_clk", dac_lr_clk, elr);
        chk("dacdat", dacdat, ed);
        chk("underrun", underrun, (lr_rise && have_cur) ? cur.und : 1'b0);
        chk("sample_ready", sample_ready, !m_full);
        chk("underrun_cnt", underrun_cnt, m_ucnt);
        if (!e_smp) begin
          in_fr = 0; have_cur = 0; last_b = -1; last_lr = -1;
        end
      end
      p_b = b_clk;
      p_lr = dac_lr_clk;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] b2b [2];
    int          idx, g;
    b2b[0] = 32'hDEAD_BEEF;
    b2b[1] = 32'hCAFE_F00D;
    repeat (3) @(negedge m_clk);
    #1;
    rst_n = 1;
    model_step();
    // first frame carries a preloaded word, then three underrun frames
    cyc(0, 1, 32'hA5C3_0F81);
    idle(H + 3 * FR + 20, 1);
    chk("ucnt after 3 underruns", underrun_cnt, 3);
    // bypass on the exact frame-start cycle
    for (g = 0; !is_fs(m_t + 1); g++) begin
      if (g > 2 * FR) begin timeout("bypass align"); break; end
      cyc(1, 0, $urandom());
    end
    cyc(1, 1, 32'h1234_5678);
    cyc(1, 0, 32'h0);
    chk("bypass keeps ready", sample_ready, 1);
    idle(FR, 1);
    // back-to-back words with valid held high
    idx = 0;
    for (g = 0; idx < 2; g++) begin
      if (g > 3 * FR) begin timeout("back-to-back accept"); break; end
      cyc(1, 1, b2b[idx]);
      if (m_xfer) idx++;
    end
    idle(3 * FR, 1);
    // randomized traffic with random enable gaps
    for (int s = 0; s < 6; s++) begin
      repeat ($urandom_range(200, 1500)) cyc(1, $urandom_range(0, 49) == 0, $urandom());
      repeat ($urandom_range(5, 40)) cyc(0, $urandom_range(0, 9) == 0, $urandom());
    end
    // disable at bit 10 with a word buffered
    for (g = 0; m_full || !is_fs(m_t); g++) begin
      if (g > 4 * FR) begin timeout("disable align"); break; end
      cyc(1, 0, $urandom());
    end
    cyc(1, 1, 32'h0BAD_CAFE);
    for (g = 0; (m_t - H) % FR != 20 * H; g++) begin
      if (g > 2 * FR) begin timeout("bit 10 align"); break; end
      cyc(1, 0, $urandom());
    end
    idle(30, 0);
    chk("buffer held while disabled", sample_ready, 0);
    chk("dacdat low while disabled", dacdat, 0);
    idle(H + FR + 10, 1);
    // reset pulse mid-frame
    idle(100, 1);
    cyc(1, 1, 32'h55AA_55AA);
    idle(40, 1);
    do_reset();
    idle(5, 0);
    chk("ucnt cleared by reset", underrun_cnt, 0);
    chk("ready after reset", sample_ready, 1);
    chk("lr after reset", dac_lr_clk, 0);
    cyc(0, 1, 32'h600D_F00D);
    idle(H + FR + 5, 1);
    idle(50, 0);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
